miriscv_data_mem: RTL and testbench
===================================

Name: miriscv_data_mem

Overview:
- Word-organised data RAM directly downstream of the core's load/store unit.
- Consumes the LSU memory-side request: req, we, byte-enable, address and write data.
- Returns the full aligned read word, plus a stall that holds the core until the access completes.
- Access latency is configurable; a small FSM and a latency counter drive the stall.

Parameters:
DEPTH_WORDS  1024           number of 32-bit words; power of two, >= 2
BASE_ADDR    32'h0000_0000  byte address of word 0; 4-byte aligned
LATENCY      2              clock cycles the stall is held per access; >= 1, <= 255

Ports:
clk_i         in   1   clock, rising edge
arstn_i       in   1   asynchronous active-low reset
data_req_i    in   1   access request from LSU, held until stall_o drops
data_we_i     in   1   1 = write, 0 = read
data_be_i     in   4   byte enables; bit n selects byte n (bits 8n+7:8n)
data_addr_i   in   32  byte address; bits [1:0] ignored
data_wdata_i  in   32  write data, already lane-replicated by LSU
data_rdata_o  out  32  read word, registered
data_stall_o  out  1   1 = access not complete, core must hold
data_err_o    out  1   one-cycle pulse: completed access was out of range

Behaviour:
- Reset (arstn_i low, asynchronous): state IDLE, counter 0, data_rdata_o = 0, data_err_o = 0, captured request cleared.
- RAM contents are not reset.
- data_stall_o is combinational: data_req_i & (state != DONE). During reset it therefore equals data_req_i.
- IDLE, data_req_i = 1:
  - Capture we, be, addr, wdata.
  - Counter <= LATENCY-1.
  - Next state: DONE if LATENCY = 1, otherwise BUSY.
- IDLE, data_req_i = 0: stay in IDLE.
- BUSY: counter decrements each cycle. Move to DONE on the edge where the counter is 1.
- Inputs changing during BUSY are ignored; only the captured request is used.
- Commit happens on the edge entering DONE:
  - Write: each byte with its captured be bit set is updated. be = 4'b0000 changes nothing.
  - Read: data_rdata_o <= RAM word; be is ignored and the full word is returned.
- DONE, exactly 1 cycle:
  - data_stall_o = 0 and data_rdata_o is valid.
  - data_err_o = 1 if the captured access was out of range.
  - Next state is always IDLE, even if data_req_i stays high. The core drops or changes the request on the following cycle.
- Timing: a request first seen in cycle t gives stall high in cycles t..t+LATENCY-1 and completion (stall low) in cycle t+LATENCY.
- A new request can be accepted in cycle t+LATENCY+1.
- data_rdata_o holds its last read value through writes and idle cycles. It updates only on read completion.
- Address decode:
  - offset = data_addr_i - BASE_ADDR, modulo 2^32.
  - Index = offset[31:2].
  - In range iff the index < DEPTH_WORDS. This also covers addresses below BASE_ADDR, which wrap to a large offset.
- Out-of-range access:
  - Write: dropped.
  - Read: returns 32'h0000_0000.
  - data_err_o pulses in the DONE cycle.
- data_req_i dropped during BUSY:
  - data_stall_o falls immediately.
  - The captured access still completes, including the write commit, and passes through DONE to IDLE.
- Reset asserted in BUSY: the pending write is discarded and RAM is unchanged. After release, state is IDLE.

Test Plan:
- LATENCY=2, write word at 0x10:
  - Stimulus: data_req_i=1, we=1, be=4'hF, wdata=32'hDEAD_BEEF, held until stall drops.
  - Response: stall high 2 cycles, low in cycle 3.
  - Then read 0x10: data_rdata_o = 32'hDEAD_BEEF in its DONE cycle.
- Partial writes to 0x20, starting from 32'h1122_3344:
  - Stimulus: write be=4'b0100 wdata=32'hAAAA_AAAA, then be=4'b0011 wdata=32'h5555_5555.
  - Response: a read of 0x20 returns 32'h11AA_5555.
  - A be=4'h0 write leaves 32'h11AA_5555 unchanged.
- Out of range, DEPTH_WORDS=1024, BASE_ADDR=0x1000:
  - Stimulus: write to 0x2000, then read 0x2000, then read 0x0FFC.
  - Response: both reads return 0 and data_err_o pulses once per access (3 pulses).
  - Word 0 (0x1000) is unmodified.
- LATENCY=1 back-to-back:
  - Stimulus: 4 reads, each request presented the cycle after the previous DONE.
  - Response: stall pattern 1,0,(idle-accept)1,0...
  - Each of the 4 reads returns its correct word.
- Request dropped and reset:
  - Write 0x40=32'h0000_00FF, deassert req in BUSY: read back 0x40 = 32'h0000_00FF.
  - Second write 0x40=32'h1234_5678 with arstn_i pulsed low mid-BUSY: a read after reset returns 32'h0000_00FF and data_rdata_o was 0 right after reset.
- Input change during BUSY, LATENCY=3:
  - Stimulus: addr switched from 0x80 to 0x84 one cycle after accept.
  - Response: the write lands at 0x80 only; 0x84 is unchanged.

Source files
------------

// File: rtl/miriscv_data_mem.sv
// Word-organised data RAM behind the load/store unit. Each access is held
// for LATENCY cycles via data_stall_o, then committed and completed in a
// single DONE cycle. Out-of-range accesses are dropped and flagged.
module miriscv_data_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_stall_o,
    output logic        data_err_o
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        commit;

    logic        cap_we_q;
    logic [3:0]  cap_be_q;
    logic [29:0] cap_addr_q;
    logic [31:0] cap_wdata_q;

    logic        acc_we;
    logic [3:0]  acc_be;
    logic [29:0] acc_addr;
    logic [31:0] acc_wdata;

    logic [29:0]   index;
    logic [AW-1:0] word_idx;
    logic          in_range;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    // Byte offset within the word never affects a word access.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^data_addr_i[1:0];

    // With LATENCY = 1 the commit edge is also the accept edge, so the live
    // request is used in IDLE and the captured one everywhere else.
    always_comb begin
        acc_we    = cap_we_q;
        acc_be    = cap_be_q;
        acc_addr  = cap_addr_q;
        acc_wdata = cap_wdata_q;
        if (state_q == StIdle) begin
            acc_we    = data_we_i;
            acc_be    = data_be_i;
            acc_addr  = data_addr_i[31:2];
            acc_wdata = data_wdata_i;
        end
    end

    // Base is word aligned, so subtracting word addresses equals offset[31:2];
    // addresses below the base wrap to a huge index and fall out of range.
    assign index    = acc_addr - BASE_ADDR[31:2];
    assign word_idx = index[AW-1:0];
    assign in_range = ({2'b00, index} < DEPTH_WORDS);

    // Next-state, latency counter and commit strobe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_req_i) begin
                    cnt_d = 8'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = StDone;
                        commit  = 1'b1;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = StDone;
                    commit  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counter and captured request.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            cap_we_q    <= 1'b0;
            cap_be_q    <= 4'b0000;
            cap_addr_q  <= 30'd0;
            cap_wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && data_req_i) begin
                cap_we_q    <= data_we_i;
                cap_be_q    <= data_be_i;
                cap_addr_q  <= data_addr_i[31:2];
                cap_wdata_q <= data_wdata_i;
            end
        end
    end

    // Read data and error pulse, both produced on the commit edge.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= commit & ~in_range;
            if (commit && !acc_we) begin
                rdata_q <= in_range ? mem[word_idx] : 32'd0;
            end
        end
    end

    // Byte-masked RAM write; storage itself is never reset.
    always_ff @(posedge clk_i) begin
        if (commit && acc_we && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[word_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign data_stall_o = data_req_i & (state_q != StDone);
    assign data_rdata_o = rdata_q;
    assign data_err_o   = err_q;

endmodule

// File: tb/tb_miriscv_data_mem.sv
// Bench for miriscv_data_mem: four instances with different geometry and
// latency, a transaction-level reference model checked every cycle, and
// directed accesses with hand-computed expected words.
module tb_miriscv_data_mem;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arstn;
    logic        req   [N];
    logic        we    [N];
    logic [3:0]  be    [N];
    logic [31:0] addr  [N];
    logic [31:0] wdata [N];
    logic [31:0] rdata [N];
    logic        stall [N];
    logic        err   [N];

    // Instance configuration: 0/1 latency 2 (1 has a non-zero base),
    // 2 latency 1 with a small depth, 3 latency 3.
    int unsigned lat_m   [N] = '{2, 2, 1, 3};
    logic [31:0] base_m  [N] = '{32'h0, 32'h1000, 32'h0, 32'h0};
    int unsigned depth_m [N] = '{1024, 1024, 16, 1024};

    miriscv_data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2)) u0 (
        .clk_i(clk), .arstn_i(arstn), .data_req_i(req[0]), .data_we_i(we[0]),
        .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
        .data_rdata_o(rdata[0]), .data_stall_o(stall[0]), .data_err_o(err[0])
    );
    miriscv_data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h1000), .LATENCY(2)) u1 (
        .clk_i(clk), .arstn_i(arstn), .data_req_i(req[1]), .data_we_i(we[1]),
        .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
        .data_rdata_o(rdata[1]), .data_stall_o(stall[1]), .data_err_o(err[1])
    );
    miriscv_data_mem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(1)) u2 (
        .clk_i(clk), .arstn_i(arstn), .data_req_i(req[2]), .data_we_i(we[2]),
        .data_be_i(be[2]), .data_addr_i(addr[2]), .data_wdata_i(wdata[2]),
        .data_rdata_o(rdata[2]), .data_stall_o(stall[2]), .data_err_o(err[2])
    );
    miriscv_data_mem #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3)) u3 (
        .clk_i(clk), .arstn_i(arstn), .data_req_i(req[3]), .data_we_i(we[3]),
        .data_be_i(be[3]), .data_addr_i(addr[3]), .data_wdata_i(wdata[3]),
        .data_rdata_o(rdata[3]), .data_stall_o(stall[3]), .data_err_o(err[3])
    );

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: an access accepted in cycle t completes in cycle
    // t + latency; its effect is applied to the model memory at that point.
    int          cyc = 0;
    bit          pend     [N];
    int          done_cyc [N];
    logic        cwe      [N];
    logic [3:0]  cbe      [N];
    logic [31:0] caddr    [N];
    logic [31:0] cwd      [N];
    logic [31:0] exp_rd   [N];
    int          errcnt   [N];
    logic [31:0] mem_m    [N][1024];

    initial begin
        logic [31:0] off;
        bit          inr;
        logic        xs, xe;
        for (int i = 0; i < N; i++) begin
            pend[i]   = 1'b0;
            exp_rd[i] = 32'd0;
            errcnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                xs = req[i];
                xe = 1'b0;
                if (!arstn) begin
                    pend[i]   = 1'b0;
                    exp_rd[i] = 32'd0;
                end else if (pend[i] && cyc == done_cyc[i]) begin
                    off = caddr[i] - base_m[i];
                    inr = (off >> 2) < depth_m[i];
                    if (cwe[i]) begin
                        if (inr) begin
                            for (int b = 0; b < 4; b++) begin
                                if (cbe[i][b]) mem_m[i][off[11:2]][8*b +: 8] = cwd[i][8*b +: 8];
                            end
                        end
                    end else begin
                        exp_rd[i] = inr ? mem_m[i][off[11:2]] : 32'd0;
                    end
                    xs = 1'b0;
                    xe = !inr;
                end
                check32($sformatf("u%0d stall c%0d", i, cyc), {31'd0, stall[i]}, {31'd0, xs});
                check32($sformatf("u%0d err c%0d", i, cyc), {31'd0, err[i]}, {31'd0, xe});
                check32($sformatf("u%0d rdata c%0d", i, cyc), rdata[i], exp_rd[i]);
                if (err[i] === 1'b1) errcnt[i]++;
            end
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                if (arstn) begin
                    if (pend[i] && cyc == done_cyc[i]) begin
                        pend[i] = 1'b0;
                    end else if (!pend[i] && req[i]) begin
                        pend[i]     = 1'b1;
                        done_cyc[i] = cyc + int'(lat_m[i]);
                        cwe[i]      = we[i];
                        cbe[i]      = be[i];
                        caddr[i]    = addr[i];
                        cwd[i]      = wdata[i];
                    end
                end
            end
            cyc++;
        end
    end

    // Present a request, hold it until stall drops, then release it.
    // Optionally swaps address/data one cycle after acceptance.
    task automatic access(input int i, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] a2, input bit chg,
                          output logic [31:0] rd, output int ns);
        req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
        ns = 0;
        @(negedge clk);
        while (stall[i] === 1'b1 && ns < 50) begin
            ns++;
            @(posedge clk); #1;
            if (chg && ns == 1) begin
                addr[i]  = a2;
                wdata[i] = ~d;
            end
            @(negedge clk);
        end
        checks++;
        if (ns >= 50) begin
            errors++;
            $display("FAIL u%0d access timeout: stall still %b, expected 0", i, stall[i]);
        end
        rd = rdata[i];
        @(posedge clk); #1;
        req[i] = 1'b0; we[i] = 1'b0;
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output int ns);
        logic [31:0] rd;
        access(i, 1'b1, b, a, d, 32'd0, 1'b0, rd, ns);
    endtask

    task automatic rdw(input int i, input logic [31:0] a, output logic [31:0] rd, output int ns);
        access(i, 1'b0, 4'hF, a, 32'd0, 32'd0, 1'b0, rd, ns);
    endtask

    initial begin
        logic [31:0] rd;
        int          ns;
        logic [31:0] vals [4];
        vals = '{32'h0102_0304, 32'hA0B0_C0D0, 32'h7777_0000, 32'h0000_9999};
        arstn = 1'b0;
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'd0; wdata[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1 arstn = 1'b1;
        @(posedge clk); #1;

        // Full write then read, latency 2.
        wr(0, 32'h10, 32'hDEAD_BEEF, 4'hF, ns);
        check32("u0 write stall cycles", ns, 2);
        rdw(0, 32'h10, rd, ns);
        check32("u0 read 0x10", rd, 32'hDEAD_BEEF);
        check32("u0 read stall cycles", ns, 2);

        // Byte-enable merging.
        wr(0, 32'h20, 32'h1122_3344, 4'hF, ns);
        wr(0, 32'h20, 32'hAAAA_AAAA, 4'b0100, ns);
        wr(0, 32'h20, 32'h5555_5555, 4'b0011, ns);
        rdw(0, 32'h20, rd, ns);
        check32("u0 partial write merge", rd, 32'h11AA_5555);
        wr(0, 32'h20, 32'hFFFF_FFFF, 4'b0000, ns);
        rdw(0, 32'h20, rd, ns);
        check32("u0 be0 write no effect", rd, 32'h11AA_5555);

        // Request dropped while busy: write still lands.
        req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h40; wdata[0] = 32'h0000_00FF;
        @(posedge clk); #1;
        req[0] = 1'b0; we[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rdw(0, 32'h40, rd, ns);
        check32("u0 dropped-req write", rd, 32'h0000_00FF);

        // Reset in the busy cycle discards the pending write.
        req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h40; wdata[0] = 32'h1234_5678;
        @(posedge clk); #1;
        arstn = 1'b0; req[0] = 1'b0; we[0] = 1'b0;
        @(negedge clk);
        check32("u0 rdata during reset", rdata[0], 32'd0);
        @(posedge clk); #1;
        arstn = 1'b1;
        @(negedge clk);
        check32("u0 rdata after reset", rdata[0], 32'd0);
        @(posedge clk); #1;
        rdw(0, 32'h40, rd, ns);
        check32("u0 write killed by reset", rd, 32'h0000_00FF);

        // Out of range with base 0x1000.
        wr(1, 32'h1000, 32'hA5A5_0001, 4'hF, ns);
        wr(1, 32'h2000, 32'hDEAD_DEAD, 4'hF, ns);
        rdw(1, 32'h2000, rd, ns);
        check32("u1 read above range", rd, 32'd0);
        rdw(1, 32'h0FFC, rd, ns);
        check32("u1 read below base", rd, 32'd0);
        check32("u1 err pulse count", errcnt[1], 3);
        rdw(1, 32'h1000, rd, ns);
        check32("u1 word 0 intact", rd, 32'hA5A5_0001);
        check32("u1 err pulse count after good read", errcnt[1], 3);

        // Latency 1, back-to-back.
        for (int k = 0; k < 4; k++) wr(2, 32'(4 * k), vals[k], 4'hF, ns);
        for (int k = 0; k < 4; k++) begin
            rdw(2, 32'(4 * k), rd, ns);
            check32($sformatf("u2 b2b read %0d", k), rd, vals[k]);
            check32($sformatf("u2 b2b stall cycles %0d", k), ns, 1);
        end

        // Latency 3: inputs changed after accept are ignored.
        wr(3, 32'h84, 32'hCAFE_0084, 4'hF, ns);
        wr(3, 32'h80, 32'h0000_0000, 4'hF, ns);
        access(3, 1'b1, 4'hF, 32'h80, 32'h1111_2222, 32'h84, 1'b1, rd, ns);
        check32("u3 stall cycles", ns, 3);
        rdw(3, 32'h80, rd, ns);
        check32("u3 captured addr written", rd, 32'h1111_2222);
        rdw(3, 32'h84, rd, ns);
        check32("u3 changed addr untouched", rd, 32'hCAFE_0084);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
